bht_predictor: RTL and testbench
================================

// Module: bht_predictor
// PURPOSE
//  Branch history table: 2^INDEX_BITS 2-bit saturating counters indexed by PC.
//  Fetch side issues lookups and receives a registered taken/not-taken prediction.
//  EX side is trained with the resolved outcome produced by the branch logic unit.
//  Flags mispredicts and counts them for performance monitoring.
// PARAMETERS
//  INDEX_BITS  6   log2 of table entries; index = pc[INDEX_BITS+1:2]
//  CNT_W       32  width of mispredict performance counter
// PORTS
//  clk                input   1           clock; all state updates on rising edge
//  rst                input   1           synchronous, active-high reset
//  ready              output  1           1 once init sweep is complete
//  lookup_valid       input   1           fetch-side lookup request
//  lookup_pc          input   64          PC of the fetched instruction
//  pred_valid         output  1           registered lookup_valid (1-cycle latency)
//  pred_taken         output  1           prediction for the PC looked up last cycle
//  update_valid       input   1           resolved conditional branch in EX
//  update_pc          input   64          PC of resolved branch
//  update_taken       input   1           actual outcome (branch logic unit 'taken')
//  update_pred_taken  input   1           prediction carried down the pipe for it
//  mispredict         output  1           registered: update_valid & (taken != pred)
//  mispredict_cnt     output  CNT_W       saturating count of mispredicts
// BEHAVIOUR
//  Reset: ready=0, pred_valid=0, pred_taken=0, mispredict=0, mispredict_cnt=0,
//   FSM -> INIT, init_idx=0. Reset asserted mid-operation aborts everything and restarts INIT.
//  FSM: INIT writes WNT(2'b01) to entry init_idx per cycle, init_idx++;
//   after writing entry 2^INDEX_BITS-1 -> READY; ready=1 registered with the transition
//   (first ready=1 cycle = cycle 2^INDEX_BITS after rst deasserts). READY is terminal until rst.
//  During INIT: updates ignored (no table write, no mispredict, no count);
//   lookups still produce pred_valid next cycle with pred_taken=0.
//  Lookup (READY): pred_valid<=lookup_valid; pred_taken<=counter[idx][1] when valid, else 0.
//  Update (READY): counter +1 if taken, -1 if not; saturate at 2'b00 and 2'b11.
//  Same-cycle lookup & update, same index: prediction uses post-update counter (forwarded).
//  Different indices: both proceed independently in the same cycle.
//  mispredict: 1-cycle pulse the cycle after a qualifying update; pulses back-to-back
//   if updates are back-to-back. mispredict_cnt increments with it, holds at all-ones.
//  PC bits above INDEX_BITS+1 and bits [1:0] are ignored (aliasing is by design).
//  Only conditional branches may drive update_valid; the upstream stage guarantees it.
// STRUCTURE
//  bht_pkg: typedef logic [1:0] bht_cnt_t; constants BHT_SNT/WNT/WT/ST = 0..3;
//   typedef enum {BHT_INIT, BHT_READY} bht_state_t.
//  Sub-module bht_sat_cnt: combinational bht_cnt_t next = f(cur, taken), saturating.
//  Table is a flop array (no SRAM macro); write port shared by INIT sweep and update mux.
// TESTING
//  rst 1 cycle then low -> ready=0 for 64 cycles, ready=1 at cycle 64; lookup during INIT -> pred_taken=0.
//  After init, lookup pc=0x1000 -> pred_taken=0 (WNT); one update taken -> next lookup pred_taken=1.
//  5 taken updates on pc=0x2004 then 2 not-taken -> counter 11->01, pred_taken=0 after 2nd.
//  Same-cycle update(taken, pc=0x3000) + lookup pc=0x3000 from WNT -> pred_taken=1 next cycle.
//  update taken=1, pred_taken=0 -> mispredict pulse 1 cycle later, mispredict_cnt 0->1; match -> no pulse.
//  Assert rst mid-training -> all outputs to reset values, INIT restarts, trained entry reads WNT after.

Source files
------------

// File: rtl/bht_pkg.sv
// Shared types and constants for the branch history table.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package bht_pkg;

   // 2-bit saturating counter: bit 1 is the taken/not-taken prediction.
   typedef logic [1:0] bht_cnt_t;

   localparam bht_cnt_t BHT_SNT = 2'b00;
   localparam bht_cnt_t BHT_WNT = 2'b01;
   localparam bht_cnt_t BHT_WT  = 2'b10;
   localparam bht_cnt_t BHT_ST  = 2'b11;

   typedef enum logic {
      BHT_INIT,
      BHT_READY
   } bht_state_t;

endpackage

// File: rtl/bht_sat_cnt.sv
// Next-state function of one 2-bit saturating branch counter.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
// Ports: i_cur  current counter value
//        i_taken resolved branch outcome
//        o_next counter value after training, clamped to SNT..ST
module bht_sat_cnt
   import bht_pkg::*;
(
   input  logic [1:0] i_cur,
   input  logic       i_taken,
   output logic [1:0] o_next
);

   always_comb begin
      o_next = i_cur;
      if (i_taken && (i_cur != BHT_ST)) begin
         o_next = i_cur + 2'd1;
      end else if (!i_taken && (i_cur != BHT_SNT)) begin
         o_next = i_cur - 2'd1;
      end
   end

endmodule

// File: rtl/bht_predictor.sv
// Branch history table of 2-bit counters; predicts on fetch, trains from EX, counts mispredicts.
// Latency: lookup -> pred_valid/pred_taken 1 cycle; update -> mispredict pulse 1 cycle.
// Backpressure: none; lookups always answered, updates ignored until ready (init sweep).
// Ports: clk/rst (sync active-high); ready after the init sweep;
//        lookup_valid/lookup_pc -> pred_valid/pred_taken;
//        update_valid/update_pc/update_taken/update_pred_taken -> mispredict/mispredict_cnt.
module bht_predictor
   import bht_pkg::*;
#(
   parameter int INDEX_BITS = 6,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   output logic             ready,
   input  logic             lookup_valid,
   input  logic [63:0]      lookup_pc,
   output logic             pred_valid,
   output logic             pred_taken,
   input  logic             update_valid,
   input  logic [63:0]      update_pc,
   input  logic             update_taken,
   input  logic             update_pred_taken,
   output logic             mispredict,
   output logic [CNT_W-1:0] mispredict_cnt
);

   localparam int ENTRIES = 1 << INDEX_BITS;

   bht_state_t              r_state;
   bht_state_t              w_state_nxt;
   logic [INDEX_BITS-1:0]   r_init_idx;
   logic [1:0]              r_table [ENTRIES];
   logic                    r_pred_valid;
   logic                    r_pred_taken;
   logic                    r_mispredict;
   logic [CNT_W-1:0]        r_mispredict_cnt;

   logic [INDEX_BITS-1:0]   w_lkp_idx;
   logic [INDEX_BITS-1:0]   w_upd_idx;
   logic [1:0]              w_upd_cur;
   logic [1:0]              w_upd_nxt;
   logic [1:0]              w_lkp_cnt;
   logic                    w_is_ready;
   logic                    w_upd_en;
   logic                    w_mispred;
   logic                    w_wr_en;
   logic [INDEX_BITS-1:0]   w_wr_idx;
   logic [1:0]              w_wr_dat;
   logic                    w_unused_pc_bits;

   // Word-aligned PCs: bits [1:0] and everything above the index alias freely.
   assign w_lkp_idx = lookup_pc[INDEX_BITS+1:2];
   assign w_upd_idx = update_pc[INDEX_BITS+1:2];
   assign w_unused_pc_bits = ^{lookup_pc[63:INDEX_BITS+2], lookup_pc[1:0],
                               update_pc[63:INDEX_BITS+2], update_pc[1:0]};

   assign w_is_ready = (r_state == BHT_READY);
   assign w_upd_en   = w_is_ready && update_valid;
   assign w_mispred  = w_upd_en && (update_taken != update_pred_taken);
   assign w_upd_cur  = r_table[w_upd_idx];

   bht_sat_cnt u_sat_cnt (
      .i_cur   (w_upd_cur),
      .i_taken (update_taken),
      .o_next  (w_upd_nxt)
   );

   // A lookup hitting the entry being trained this cycle sees the trained value.
   assign w_lkp_cnt = (w_upd_en && (w_upd_idx == w_lkp_idx)) ? w_upd_nxt : r_table[w_lkp_idx];

   // Single table write port: owned by the init sweep, then by the update path.
   always_comb begin
      w_state_nxt = r_state;
      w_wr_en     = 1'b0;
      w_wr_idx    = r_init_idx;
      w_wr_dat    = BHT_WNT;
      case (r_state)
         BHT_INIT: begin
            w_wr_en = 1'b1;
            if (r_init_idx == {INDEX_BITS{1'b1}}) begin
               w_state_nxt = BHT_READY;
            end
         end
         BHT_READY: begin
            w_wr_en  = w_upd_en;
            w_wr_idx = w_upd_idx;
            w_wr_dat = w_upd_nxt;
         end
         default: begin
            w_state_nxt = BHT_INIT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state          <= BHT_INIT;
         r_init_idx       <= '0;
         r_pred_valid     <= 1'b0;
         r_pred_taken     <= 1'b0;
         r_mispredict     <= 1'b0;
         r_mispredict_cnt <= '0;
      end else begin
         r_state      <= w_state_nxt;
         if (r_state == BHT_INIT) begin
            r_init_idx <= r_init_idx + {{(INDEX_BITS-1){1'b0}}, 1'b1};
         end
         r_pred_valid <= lookup_valid;
         // Table contents are meaningless until the sweep completes.
         r_pred_taken <= lookup_valid && w_is_ready && w_lkp_cnt[1];
         r_mispredict <= w_mispred;
         if (w_mispred && (r_mispredict_cnt != {CNT_W{1'b1}})) begin
            r_mispredict_cnt <= r_mispredict_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   // No reset on the table itself: the init sweep writes every entry.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_table[w_wr_idx] <= w_wr_dat;
      end
   end

   assign ready          = w_is_ready;
   assign pred_valid     = r_pred_valid;
   assign pred_taken     = r_pred_taken;
   assign mispredict     = r_mispredict;
   assign mispredict_cnt = r_mispredict_cnt;

endmodule

// File: tb/tb_bht_predictor.sv
// Directed bench for bht_predictor: init timing, training, forwarding, mispredict counting.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_bht_predictor;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          ready;
   logic          lookup_valid;
   logic [63:0]   lookup_pc;
   logic          pred_valid;
   logic          pred_taken;
   logic          update_valid;
   logic [63:0]   update_pc;
   logic          update_taken;
   logic          update_pred_taken;
   logic          mispredict;
   logic [CW-1:0] mispredict_cnt;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic          lv;
      logic [63:0]   lpc;
      logic          uv;
      logic [63:0]   upc;
      logic          ut;
      logic          up;
      logic          epv;
      logic          ept;
      logic          emp;
      logic [CW-1:0] ecnt;
   } vec_t;

   vec_t vecs [19];

   bht_predictor #(.INDEX_BITS(6), .CNT_W(CW)) dut (
      .clk               (clk),
      .rst               (rst),
      .ready             (ready),
      .lookup_valid      (lookup_valid),
      .lookup_pc         (lookup_pc),
      .pred_valid        (pred_valid),
      .pred_taken        (pred_taken),
      .update_valid      (update_valid),
      .update_pc         (update_pc),
      .update_taken      (update_taken),
      .update_pred_taken (update_pred_taken),
      .mispredict        (mispredict),
      .mispredict_cnt    (mispredict_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      lookup_valid      = v.lv;
      lookup_pc         = v.lpc;
      update_valid      = v.uv;
      update_pc         = v.upc;
      update_taken      = v.ut;
      update_pred_taken = v.up;
   endtask

   task automatic step(input vec_t v, input string nm);
      drive(v);
      @(posedge clk);
      #1;
      chk({nm, " ready"},      ready,          1'b1);
      chk({nm, " pred_valid"}, pred_valid,     v.epv);
      chk({nm, " pred_taken"}, pred_taken,     v.ept);
      chk({nm, " mispredict"}, mispredict,     v.emp);
      chk({nm, " cnt"},        mispredict_cnt, v.ecnt);
   endtask

   // Called just after rst drops. Drives a lookup and a would-be mispredict
   // for the whole sweep; both must be inert until ready.
   task automatic run_init(input string tag);
      vec_t v;
      v = '{lv:1'b1, lpc:64'h1000, uv:1'b1, upc:64'h1000, ut:1'b1, up:1'b0,
            epv:1'b0, ept:1'b0, emp:1'b0, ecnt:'0};
      drive(v);
      for (int n = 1; n <= 64; n++) begin
         @(posedge clk);
         #1;
         if (n == 1) begin
            chk({tag, " init pred_valid"}, pred_valid, 1'b1);
            chk({tag, " init pred_taken"}, pred_taken, 1'b0);
            chk({tag, " init mispredict"}, mispredict, 1'b0);
         end
         if (n == 63) chk({tag, " ready@63"}, ready, 1'b0);
         if (n == 64) begin
            chk({tag, " ready@64"},        ready,          1'b1);
            chk({tag, " init pred_taken"}, pred_taken,     1'b0);
            chk({tag, " init cnt"},        mispredict_cnt, 4'd0);
            chk({tag, " init mispredict"}, mispredict,     1'b0);
         end
      end
      v.lv = 1'b0;
      v.uv = 1'b0;
      drive(v);
   endtask

   initial begin
      vec_t v;
      logic [CW-1:0] ecnt;

      // Index 0: 0x1000/0x3000/0x3100; index 1: 0x2004/0x2007. All start WNT.
      vecs[0]  = '{lv:1, lpc:64'h1000, uv:0, upc:64'h0,    ut:0, up:0, epv:1, ept:0, emp:0, ecnt:4'd0};
      vecs[1]  = '{lv:0, lpc:64'h0,    uv:1, upc:64'h1000, ut:1, up:0, epv:0, ept:0, emp:1, ecnt:4'd1};
      vecs[2]  = '{lv:1, lpc:64'h1000, uv:0, upc:64'h0,    ut:0, up:0, epv:1, ept:1, emp:0, ecnt:4'd1};
      vecs[3]  = '{lv:1, lpc:64'h2004, uv:1, upc:64'h1000, ut:0, up:1, epv:1, ept:0, emp:1, ecnt:4'd2};
      vecs[4]  = '{lv:1, lpc:64'h3000, uv:1, upc:64'h3000, ut:1, up:1, epv:1, ept:1, emp:0, ecnt:4'd2};
      vecs[5]  = '{lv:1, lpc:64'h3100, uv:0, upc:64'h0,    ut:0, up:0, epv:1, ept:1, emp:0, ecnt:4'd2};
      vecs[6]  = '{lv:1, lpc:64'h1000, uv:1, upc:64'h2004, ut:1, up:0, epv:1, ept:1, emp:1, ecnt:4'd3};
      vecs[7]  = '{lv:0, lpc:64'h0,    uv:1, upc:64'h2004, ut:1, up:1, epv:0, ept:0, emp:0, ecnt:4'd3};
      vecs[8]  = '{lv:0, lpc:64'h0,    uv:1, upc:64'h2004, ut:1, up:1, epv:0, ept:0, emp:0, ecnt:4'd3};
      vecs[9]  = '{lv:0, lpc:64'h0,    uv:1, upc:64'h2004, ut:1, up:1, epv:0, ept:0, emp:0, ecnt:4'd3};
      vecs[10] = '{lv:0, lpc:64'h0,    uv:1, upc:64'h2004, ut:1, up:1, epv:0, ept:0, emp:0, ecnt:4'd3};
      vecs[11] = '{lv:1, lpc:64'h2004, uv:0, upc:64'h0,    ut:0, up:0, epv:1, ept:1, emp:0, ecnt:4'd3};
      vecs[12] = '{lv:1, lpc:64'h2004, uv:1, upc:64'h2004, ut:0, up:1, epv:1, ept:1, emp:1, ecnt:4'd4};
      vecs[13] = '{lv:1, lpc:64'h2007, uv:1, upc:64'h2004, ut:0, up:1, epv:1, ept:0, emp:1, ecnt:4'd5};
      vecs[14] = '{lv:1, lpc:64'h2004, uv:0, upc:64'h0,    ut:0, up:0, epv:1, ept:0, emp:0, ecnt:4'd5};
      vecs[15] = '{lv:0, lpc:64'h0,    uv:1, upc:64'h2004, ut:0, up:0, epv:0, ept:0, emp:0, ecnt:4'd5};
      vecs[16] = '{lv:1, lpc:64'h2004, uv:1, upc:64'h2004, ut:0, up:0, epv:1, ept:0, emp:0, ecnt:4'd5};
      vecs[17] = '{lv:1, lpc:64'h2004, uv:1, upc:64'h2004, ut:1, up:0, epv:1, ept:0, emp:1, ecnt:4'd6};
      vecs[18] = '{lv:1, lpc:64'h2004, uv:1, upc:64'h2004, ut:1, up:1, epv:1, ept:1, emp:0, ecnt:4'd6};

      v = '{lv:0, lpc:64'h0, uv:0, upc:64'h0, ut:0, up:0, epv:0, ept:0, emp:0, ecnt:'0};
      drive(v);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst ready",      ready,          1'b0);
      chk("rst pred_valid", pred_valid,     1'b0);
      chk("rst pred_taken", pred_taken,     1'b0);
      chk("rst mispredict", mispredict,     1'b0);
      chk("rst cnt",        mispredict_cnt, 4'd0);
      rst = 1'b0;
      run_init("boot");

      for (int i = 0; i < 19; i++) begin
         step(vecs[i], $sformatf("vec%0d", i));
      end

      // Reset in the middle of training: index 1 currently holds WT.
      v = '{lv:1, lpc:64'h2004, uv:1, upc:64'h2004, ut:1, up:0, epv:0, ept:0, emp:0, ecnt:'0};
      drive(v);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst ready",      ready,          1'b0);
      chk("midrst pred_valid", pred_valid,     1'b0);
      chk("midrst pred_taken", pred_taken,     1'b0);
      chk("midrst mispredict", mispredict,     1'b0);
      chk("midrst cnt",        mispredict_cnt, 4'd0);
      rst = 1'b0;
      run_init("rerun");

      step('{lv:1, lpc:64'h2004, uv:0, upc:64'h0,    ut:0, up:0, epv:1, ept:0, emp:0, ecnt:4'd0}, "post lookup wnt");
      step('{lv:0, lpc:64'h0,    uv:1, upc:64'h2004, ut:1, up:0, epv:0, ept:0, emp:1, ecnt:4'd1}, "post mispredict");
      step('{lv:1, lpc:64'h2004, uv:0, upc:64'h0,    ut:0, up:0, epv:1, ept:1, emp:0, ecnt:4'd1}, "post lookup wt");

      // Back-to-back mispredicts drive the 4-bit counter into saturation.
      ecnt = 4'd1;
      for (int i = 0; i < 16; i++) begin
         if (ecnt != 4'hF) ecnt = ecnt + 4'd1;
         v = '{lv:0, lpc:64'h0, uv:1, upc:64'h1000, ut:1, up:0, epv:0, ept:0, emp:1, ecnt:ecnt};
         step(v, $sformatf("sat%0d", i));
      end

      v = '{lv:0, lpc:64'h0, uv:0, upc:64'h0, ut:0, up:0, epv:0, ept:0, emp:0, ecnt:4'hF};
      step(v, "sat hold");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
